board_vga_renderer: RTL and testbench

//  Display-side consumer of the minesweeper board bus: reads the 8x8 array of 9-bit cells and the win/lose flags.

---
 rtl/board_vga_renderer.sv | 237 +++++++++++++++++++++++
 tb/tb_board_vga_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/board_vga_renderer.sv
// Purpose: paints the 8x8 minesweeper board as a centred tile grid on 640x480@60 VGA.
// Latency: colour/sync/blank for pixel (h,v) appear 2 pix_en ticks after the counters reach (h,v).
// Backpressure: none; every register advances only on pix_en, otherwise all outputs hold. DIGIT_GLYPH_EN selects 7-segment digits.
module board_vga_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int TILE     = 60,
    parameter int X_OFF    = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [8:0] board_in [8][8],
    input  logic       lose,
    input  logic       win,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] GX_PRE = 10'(X_OFF - 1);
    localparam logic [9:0] GX_BEG = 10'(X_OFF);
    localparam logic [9:0] GX_END = 10'(X_OFF + 8 * TILE - 1);
    localparam logic [5:0] T_LAST = 6'(TILE - 1);
    localparam logic [5:0] BAND_HI_BEG = 6'(TILE - 4);
    localparam logic [5:0] BAND_HI_END = 6'(TILE - 2);

    // S0: raster counters plus tile-local counters (no dividers)
    logic [9:0] hcnt, vcnt;
    logic [5:0] tx, ty;
    logic [2:0] col, row;

    // Snapshot of the board taken once per frame
    logic [8:0] snap [8][8];
    logic       snap_lose, snap_win;

    // S1: fetched cell and region decode
    logic       blank1, hs1, vs1, grid1;
    logic [5:0] tx1, ty1;
    logic [8:0] cell1;

    // S1 -> S2 colour decode
    logic [3:0]  n;
    logic [23:0] digit_rgb;
    logic [23:0] rgb_nx;
    logic        tile_edge, cur_band;
    logic        rsvd_unused;

    assign rsvd_unused = cell1[4];
    assign vga_sync_n  = 1'b0;
    assign frame_start = pix_en & ~rst & (hcnt == 10'd0) & (vcnt == 10'd0);

    // Raster and tile counters; tx/col restart at the grid's left edge, ty/row at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            tx   <= '0;
            col  <= '0;
            ty   <= '0;
            row  <= '0;
        end else if (pix_en) begin
            hcnt <= (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
            if (hcnt == GX_PRE) begin
                tx  <= '0;
                col <= '0;
            end else if (tx == T_LAST) begin
                tx  <= '0;
                col <= col + 3'd1;
            end else begin
                tx <= tx + 6'd1;
            end
            if (hcnt == H_LAST) begin
                if (vcnt == V_LAST) begin
                    vcnt <= '0;
                    ty   <= '0;
                    row  <= '0;
                end else begin
                    vcnt <= vcnt + 10'd1;
                    if (ty == T_LAST) begin
                        ty  <= '0;
                        row <= row + 3'd1;
                    end else begin
                        ty <= ty + 6'd1;
                    end
                end
            end
        end
    end

    // Capture board and flags at the first vblank pixel so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    snap[r][c] <= '0;
            snap_lose <= 1'b0;
            snap_win  <= 1'b0;
        end else if (pix_en && hcnt == 10'd0 && vcnt == V_ACT) begin
            snap      <= board_in;
            snap_lose <= lose;
            snap_win  <= win;
        end
    end

    // S1: region decode and cell fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            blank1 <= 1'b1;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            grid1  <= 1'b0;
            tx1    <= '0;
            ty1    <= '0;
            cell1  <= '0;
        end else if (pix_en) begin
            blank1 <= (hcnt >= H_ACT) || (vcnt >= V_ACT);
            hs1    <= !((hcnt >= HS_BEG) && (hcnt <= HS_END));
            vs1    <= !((vcnt >= VS_BEG) && (vcnt <= VS_END));
            grid1  <= (hcnt >= GX_BEG) && (hcnt <= GX_END);
            tx1    <= tx;
            ty1    <= ty;
            cell1  <= snap[row][col];
        end
    end

`ifdef DIGIT_GLYPH_EN
    localparam int         G_W  = (TILE + 14) / 15;
    localparam logic [5:0] G_L  = 6'(TILE / 3);
    localparam logic [5:0] G_R  = 6'(TILE / 3 + TILE / 3 - 1);
    localparam logic [5:0] G_T  = 6'(TILE / 5);
    localparam logic [5:0] G_B  = 6'(TILE / 5 + (3 * TILE) / 5 - 1);
    localparam logic [5:0] G_M  = 6'(TILE / 5 + ((3 * TILE) / 5 - G_W) / 2);
    localparam logic [5:0] G_AE = 6'(TILE / 5 + G_W - 1);
    localparam logic [5:0] G_ME = 6'(TILE / 5 + ((3 * TILE) / 5 - G_W) / 2 + G_W - 1);
    localparam logic [5:0] G_DB = 6'(TILE / 5 + (3 * TILE) / 5 - G_W);
    localparam logic [5:0] G_LE = 6'(TILE / 3 + G_W - 1);
    localparam logic [5:0] G_RB = 6'(TILE / 3 + TILE / 3 - G_W);
    logic       in_w, left_c, right_c;
    logic [6:0] segs, mask;

    // Seven-segment glyph hit test, segment order {a,b,c,d,e,f,g}
    always_comb begin
        in_w    = (tx1 >= G_L) && (tx1 <= G_R);
        left_c  = (tx1 >= G_L) && (tx1 <= G_LE);
        right_c = (tx1 >= G_RB) && (tx1 <= G_R);
        segs[6] = in_w && (ty1 >= G_T) && (ty1 <= G_AE);
        segs[5] = right_c && (ty1 >= G_T) && (ty1 <= G_ME);
        segs[4] = right_c && (ty1 >= G_M) && (ty1 <= G_B);
        segs[3] = in_w && (ty1 >= G_DB) && (ty1 <= G_B);
        segs[2] = left_c && (ty1 >= G_M) && (ty1 <= G_B);
        segs[1] = left_c && (ty1 >= G_T) && (ty1 <= G_ME);
        segs[0] = in_w && (ty1 >= G_M) && (ty1 <= G_ME);
        case (n)
            4'd1:    mask = 7'b0110000;
            4'd2:    mask = 7'b1101101;
            4'd3:    mask = 7'b1111001;
            4'd4:    mask = 7'b0110011;
            4'd5:    mask = 7'b1011011;
            4'd6:    mask = 7'b1011111;
            4'd7:    mask = 7'b1110000;
            4'd8:    mask = 7'b1111111;
            default: mask = 7'b0000000;
        endcase
        digit_rgb = (|(segs & mask)) ? 24'h000000 : 24'hC0C0C0;
    end
`else
    logic [7:0] shade;

    // Flat grey shade that darkens with the neighbour count
    always_comb begin
        shade     = 8'hC0 - {n, 4'h0};
        digit_rgb = {shade, shade, shade};
    end
`endif

    // Colour priority decode; flags come straight from the snapshot, which only changes in vblank
    always_comb begin
        rgb_nx    = 24'h000000;
        n         = (cell1[3:0] > 4'd8) ? 4'd8 : cell1[3:0];
        tile_edge = (tx1 == 6'd0) || (tx1 == T_LAST) || (ty1 == 6'd0) || (ty1 == T_LAST);
        cur_band  = ((tx1 >= 6'd1) && (tx1 <= 6'd3)) || ((tx1 >= BAND_HI_BEG) && (tx1 <= BAND_HI_END)) ||
                    ((ty1 >= 6'd1) && (ty1 <= 6'd3)) || ((ty1 >= BAND_HI_BEG) && (ty1 <= BAND_HI_END));
        if (blank1)
            rgb_nx = 24'h000000;
        else if (!grid1)
            rgb_nx = snap_lose ? 24'h800000 : (snap_win ? 24'h008000 : 24'h202020);
        else if (tile_edge)
            rgb_nx = 24'h000000;
        else if (cell1[7] && cur_band)
            rgb_nx = 24'hFFFF00;
        else if (cell1[5] && (cell1[8] || snap_lose))
            rgb_nx = 24'hFF0000;
        else if (!cell1[8])
            rgb_nx = cell1[6] ? 24'hFF8000 : 24'h404080;
        else
            rgb_nx = digit_rgb;
    end

    // S2: aligned output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            vga_hsync   <= hs1;
            vga_vsync   <= vs1;
            vga_blank_n <= !blank1;
            {vga_r, vga_g, vga_b} <= rgb_nx;
        end
    end
endmodule

// File: tb/tb_board_vga_renderer.sv
// Bench for board_vga_renderer on a scaled raster: 80x64 visible, 96x71 total, 8 px tiles, grid x 8..71.
// Expected pixels are queued by the stimulus and retired by a monitor that tracks the output pixel index.
// Sync/blank shape and frame_start are checked continuously against hand-derived windows.
module tb_board_vga_renderer;
    localparam int HT = 96;
    localparam int VT = 71;
    localparam int FR = HT * VT;
    localparam int XO = 8;

    logic       clk = 1'b0;
    logic       rst, pix_en, lose, win;
    logic [8:0] board [8][8];
    logic       vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;

    board_vga_renderer #(
        .H_ACTIVE(80), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(64), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .TILE(8), .X_OFF(XO)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .board_in(board),
        .lose(lose), .win(win),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [23:0] rgb;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick = 0;
    int   seen_tick = 0;
    bit   half_rate = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", nm, act, req, tick);
        end
    endtask

    task automatic push(input int f, input int h, input int v, input logic [23:0] c, input string nm);
        exp_q.push_back('{f * FR + v * HT + h, c, nm});
    endtask

    task automatic pushc(input int f, input int r, input int c, input int tx, input int ty,
                         input logic [23:0] rgb, input string nm);
        push(f, XO + 8 * c + tx, 8 * r + ty, rgb, nm);
    endtask

    task automatic adv_to(input int target);
        int guard = 0;
        while (tick < target && guard < 40000) begin
            @(posedge clk);
            #2;
            pix_en = half_rate ? ~pix_en : 1'b1;
            guard++;
        end
        if (tick < target) chk("advance_timeout", tick, target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, vga_hsync, 1'b1);
        chk({tag, "_vsync"}, vga_vsync, 1'b1);
        chk({tag, "_blank_n"}, vga_blank_n, 1'b0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'h0);
        chk({tag, "_frame_start"}, frame_start, 1'b0);
        chk({tag, "_sync_n"}, vga_sync_n, 1'b0);
    endtask

    // Tick counter: number of pix_en edges since reset release = index the counters hold
    always @(posedge clk) begin
        if (rst) tick <= 0;
        else if (pix_en) tick <= tick + 1;
    end

    // Monitor: frame_start on the tick at (0,0); after tick n the outputs show pixel n-2
    int   mp, mh, mv;
    logic ex_fs, ex_blank;
    always @(negedge clk) begin
        if (rst) begin
            seen_tick = 0;
        end else begin
            ex_fs = pix_en && (tick % FR == 0);
            if (ex_fs || frame_start) chk("frame_start", frame_start, ex_fs);
            if (tick != seen_tick) begin
                seen_tick = tick;
                mp = tick - 2;
                if (mp < 0) begin
                    chk("pipe_fill_hsync", vga_hsync, 1'b1);
                    chk("pipe_fill_blank_n", vga_blank_n, 1'b0);
                end else begin
                    mh = mp % HT;
                    mv = (mp / HT) % VT;
                    ex_blank = (mh >= 80) || (mv >= 64);
                    chk("hsync", vga_hsync, !(mh >= 84 && mh <= 89));
                    chk("vsync", vga_vsync, !(mv >= 66 && mv <= 67));
                    chk("blank_n", vga_blank_n, !ex_blank);
                    if (ex_blank) chk("blank_rgb", {vga_r, vga_g, vga_b}, 24'h0);
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].idx == mp) begin
                            chk(exp_q[i].nm, {vga_r, vga_g, vga_b}, exp_q[i].rgb);
                            exp_q.delete(i);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pix_en = 1'b1;
        lose   = 1'b0;
        win    = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[r][c] = 9'h000;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");

        board[0][0] = 9'h120;
        board[7][7] = 9'h040;
        board[2][2] = 9'h103;
        board[1][1] = 9'h080;
        board[4][4] = 9'h10A;

        // Frame 0: cleared snapshot
        push(0, 2, 2, 24'h202020, "f0_border");
        pushc(0, 0, 0, 3, 3, 24'h404080, "f0_cleared_cell");
        pushc(0, 1, 1, 1, 4, 24'h404080, "f0_cursor_not_yet");
        push(0, XO, 0, 24'h000000, "f0_grid_corner");
        // Frame 1: board captured during frame 0 vblank
        pushc(1, 0, 0, 3, 3, 24'hFF0000, "f1_revealed_bomb");
        pushc(1, 7, 7, 3, 3, 24'hFF8000, "f1_flag");
        push(1, XO, 0, 24'h000000, "f1_grid_line");
        push(1, 2, 2, 24'h202020, "f1_border_left");
        push(1, 75, 5, 24'h202020, "f1_border_right");
        pushc(1, 1, 1, 1, 4, 24'hFFFF00, "f1_cursor_band");
        pushc(1, 1, 1, 0, 4, 24'h000000, "f1_grid_over_cursor");
        pushc(1, 5, 0, 3, 3, 24'h404080, "f1_hidden");
`ifdef DIGIT_GLYPH_EN
        pushc(1, 2, 2, 2, 2, 24'h000000, "f1_digit3_seg");
        pushc(1, 2, 2, 6, 6, 24'hC0C0C0, "f1_digit3_bg");
        pushc(1, 4, 4, 2, 2, 24'h000000, "f1_clamped8_seg");
`else
        pushc(1, 2, 2, 2, 2, 24'h909090, "f1_digit3_shade");
        pushc(1, 2, 2, 6, 6, 24'h909090, "f1_digit3_shade_b");
        pushc(1, 4, 4, 2, 2, 24'h404040, "f1_clamped8_shade");
`endif
        // Frame 2: lose set, cell[0][0] now revealed empty
        pushc(2, 0, 0, 3, 3, 24'hC0C0C0, "f2_new_cell00");
        push(2, 2, 2, 24'h800000, "f2_lose_border");
        pushc(2, 3, 3, 3, 3, 24'hFF0000, "f2_lose_bomb");
        pushc(2, 7, 7, 3, 3, 24'hFF8000, "f2_flag_kept");
        // Frame 3: lose and win both set
        push(3, 2, 2, 24'h800000, "f3_lose_beats_win");
        push(3, 75, 60, 24'h800000, "f3_lose_beats_win_b");
        // Frame 4: win only
        push(4, 2, 2, 24'h008000, "f4_win_border");
        pushc(4, 3, 3, 3, 3, 24'h404080, "f4_bomb_hidden");

        rst = 1'b0;
        half_rate = 1'b1;
        adv_to(FR);
        half_rate = 1'b0;
        adv_to(FR + 2 * HT);
        board[0][0] = 9'h100;
        adv_to(FR + 30 * HT);
        lose = 1'b1;
        board[3][3] = 9'h020;
        adv_to(2 * FR + 10 * HT);
        win = 1'b1;
        adv_to(3 * FR + 10 * HT);
        lose = 1'b0;
        adv_to(4 * FR + 40 * HT);
        chk("queue_drained_pre_reset", exp_q.size(), 0);

        // Reset in the middle of a frame: everything restarts at (0,0) with a cleared snapshot
        rst = 1'b1;
        pix_en = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        chk_reset_outputs("midreset");
        push(0, 2, 2, 24'h202020, "post_reset_border");
        pushc(0, 0, 0, 3, 3, 24'h404080, "post_reset_cell");
        rst = 1'b0;
        adv_to(5 * HT);
        chk("queue_drained_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
